booth_mult_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one Booth_Multiplier instance among NUM_REQ requesters.
- Accepts an operand pair from the winning requester and latches it.
- Drives the multiplier load strobes, waits for its done flag (ld_p), and returns the product to the granted requester.
- Includes a watchdog that aborts a hung multiply and flags an error.
- Sits between client blocks and the multiplier top; the multiplier's own Datapath/Controller are untouched.

---
 rtl/booth_mult_arbiter.sv | 156 +++++++++++++++
 tb/tb_booth_mult_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/booth_mult_arbiter.sv
// Round-robin arbiter sharing one Booth multiplier among NUM_REQ clients.
// Latches the winner's operands, sequences ld/ld_PP and guards with a watchdog.
module booth_mult_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int Width_inputs  = 16,
  parameter int Width_product = 32,
  parameter int TIMEOUT       = 40
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_REQ-1:0]              req,
  input  logic [NUM_REQ*Width_inputs-1:0] req_a,
  input  logic [NUM_REQ*Width_inputs-1:0] req_b,
  output logic [NUM_REQ-1:0]              grant,
  output logic [NUM_REQ-1:0]              resp_valid,
  output logic                            resp_err,
  output logic [Width_product-1:0]        resp_product,
  output logic                            busy,
  output logic [Width_inputs-1:0]         mul_in_A,
  output logic [Width_inputs-1:0]         mul_in_B,
  output logic                            mul_ld,
  output logic                            mul_ld_PP,
  input  logic                            mul_ld_p,
  input  logic [Width_product-1:0]        mul_product
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    WAIT,
    RESP
  } state_t;

  state_t                     state_q, state_d;
  logic [PW-1:0]              ptr_q, ptr_d;
  logic [PW-1:0]              own_q, own_d;
  logic [NUM_REQ-1:0]         grant_q, grant_d;
  logic [Width_inputs-1:0]    op_a_q, op_a_d;
  logic [Width_inputs-1:0]    op_b_q, op_b_d;
  logic [WW-1:0]              wdog_q, wdog_d;
  logic [Width_product-1:0]   prod_q, prod_d;
  logic                       err_q, err_d;

  logic                       found;
  logic [PW-1:0]              win_idx;
  int                         idx;

  // first requester at or after the pointer, wrapping around
  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    idx     = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req[idx]) begin
        found   = 1'b1;
        win_idx = PW'(idx);
      end
    end
  end

  // sequencer next-state and datapath updates
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    own_d   = own_q;
    grant_d = grant_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    wdog_d  = wdog_q;
    prod_d  = prod_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          own_d   = win_idx;
          grant_d = '0;
          grant_d[win_idx] = 1'b1;
          op_a_d  = req_a[int'(win_idx)*Width_inputs +: Width_inputs];
          op_b_d  = req_b[int'(win_idx)*Width_inputs +: Width_inputs];
          state_d = LOAD;
        end
      end
      LOAD: begin
        state_d = START;
      end
      START: begin
        wdog_d  = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (mul_ld_p) begin
          prod_d  = mul_product;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (wdog_q == WW'(TIMEOUT - 1)) begin
          prod_d  = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          wdog_d  = wdog_q + WW'(1);
        end
      end
      RESP: begin
        if (own_q == PW'(NUM_REQ - 1)) ptr_d = '0;
        else                           ptr_d = own_q + PW'(1);
        grant_d = '0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // state and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      own_q   <= '0;
      grant_q <= '0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      wdog_q  <= '0;
      prod_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      own_q   <= own_d;
      grant_q <= grant_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      wdog_q  <= wdog_d;
      prod_q  <= prod_d;
      err_q   <= err_d;
    end
  end

  assign grant        = grant_q;
  assign resp_valid   = (state_q == RESP) ? grant_q : '0;
  assign resp_err     = err_q;
  assign resp_product = prod_q;
  assign busy         = (state_q != IDLE);
  assign mul_in_A     = op_a_q;
  assign mul_in_B     = op_b_q;
  assign mul_ld       = (state_q == LOAD);
  assign mul_ld_PP    = (state_q == START);

endmodule

// File: tb/tb_booth_mult_arbiter.sv
// Randomized self-checking bench for booth_mult_arbiter.
// Includes a behavioural multiplier with programmable latency or hang.
module tb_booth_mult_arbiter;

  localparam int NR = 4;
  localparam int WI = 16;
  localparam int WP = 32;
  localparam int TO = 40;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [NR-1:0]     req = '0;
  logic [NR*WI-1:0]  req_a = '0;
  logic [NR*WI-1:0]  req_b = '0;
  logic [NR-1:0]     grant;
  logic [NR-1:0]     resp_valid;
  logic              resp_err;
  logic [WP-1:0]     resp_product;
  logic              busy;
  logic [WI-1:0]     mul_in_A;
  logic [WI-1:0]     mul_in_B;
  logic              mul_ld;
  logic              mul_ld_PP;
  logic              mul_ld_p;
  logic [WP-1:0]     mul_product;

  int n_checks = 0;
  int n_errors = 0;
  int ref_ptr = 0;

  booth_mult_arbiter #(
    .NUM_REQ(NR), .Width_inputs(WI), .Width_product(WP), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .req_a(req_a), .req_b(req_b),
    .grant(grant), .resp_valid(resp_valid), .resp_err(resp_err),
    .resp_product(resp_product), .busy(busy),
    .mul_in_A(mul_in_A), .mul_in_B(mul_in_B),
    .mul_ld(mul_ld), .mul_ld_PP(mul_ld_PP),
    .mul_ld_p(mul_ld_p), .mul_product(mul_product)
  );

  always #5 clk = ~clk;

  // multiplier model: ld_p raised m_lat cycles into WAIT
  logic [WI-1:0]        m_a, m_b;
  int                   m_cnt;
  logic                 m_run;
  int                   m_lat = 0;
  bit                   m_hang = 1'b0;
  logic                 extra_ldp = 1'b0;
  logic                 model_ldp;
  logic signed [WP-1:0] m_prod;

  assign model_ldp = m_run && !m_hang && (m_cnt == 0);
  assign mul_ld_p  = model_ldp | extra_ldp;

  always_comb begin
    m_prod = $signed(m_a) * $signed(m_b);
  end
  assign mul_product = m_hang ? 32'hDEADBEEF : m_prod;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_run <= 1'b0;
      m_cnt <= 0;
      m_a   <= '0;
      m_b   <= '0;
    end else begin
      if (mul_ld) begin
        m_a <= mul_in_A;
        m_b <= mul_in_B;
      end
      if (mul_ld_PP) begin
        m_run <= 1'b1;
        m_cnt <= m_lat;
      end else if (m_run) begin
        if (model_ldp) m_run <= 1'b0;
        else if (m_cnt > 0) m_cnt <= m_cnt - 1;
      end
    end
  end

  // one full transaction checked against the reference rules
  task automatic run_op(input logic [NR-1:0] r, input logic [NR*WI-1:0] a,
                        input logic [NR*WI-1:0] b, input int lat,
                        input bit hang, input bit keep, input bit scramble);
    int win, waits, cyc, exp_w;
    logic [NR-1:0] exp_g;
    logic [WI-1:0] ea, eb;
    logic signed [WI-1:0] sa, sb;
    logic signed [WP-1:0] ep;
    win = -1;
    for (int k = 0; k < NR; k++) begin
      int j;
      j = (ref_ptr + k) % NR;
      if (win < 0 && r[j]) win = j;
    end
    if (win < 0) win = 0;
    exp_g = '0;
    exp_g[win] = 1'b1;
    ea = a[win*WI +: WI];
    eb = b[win*WI +: WI];
    sa = ea;
    sb = eb;
    if (hang) ep = '0;
    else ep = sa * sb;
    exp_w = hang ? TO : lat + 1;
    m_lat = lat;
    m_hang = hang;
    req = r;
    req_a = a;
    req_b = b;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (grant == '0 && cyc < 6);
    n_checks++;
    if (grant !== exp_g) begin
      n_errors++;
      $display("FAIL grant: got %b want %b", grant, exp_g);
    end
    n_checks++;
    if ({mul_ld, mul_ld_PP} !== 2'b10) begin
      n_errors++;
      $display("FAIL load_pulse: got ld=%b ldpp=%b want 1 0", mul_ld, mul_ld_PP);
    end
    n_checks++;
    if ({mul_in_A, mul_in_B} !== {ea, eb}) begin
      n_errors++;
      $display("FAIL operands: got %h %h want %h %h", mul_in_A, mul_in_B, ea, eb);
    end
    @(negedge clk);
    n_checks++;
    if ({mul_ld, mul_ld_PP} !== 2'b01) begin
      n_errors++;
      $display("FAIL start_pulse: got ld=%b ldpp=%b want 0 1", mul_ld, mul_ld_PP);
    end
    waits = 0;
    for (int i = 0; i < TO + 10; i++) begin
      @(negedge clk);
      if (resp_valid != '0) break;
      waits++;
      if (scramble) begin
        req_a = {$urandom, $urandom};
        req_b = {$urandom, $urandom};
      end
    end
    n_checks++;
    if (resp_valid !== exp_g) begin
      n_errors++;
      $display("FAIL resp_valid: got %b want %b", resp_valid, exp_g);
    end
    n_checks++;
    if (waits !== exp_w) begin
      n_errors++;
      $display("FAIL wait_cycles: got %0d want %0d", waits, exp_w);
    end
    n_checks++;
    if (resp_err !== hang) begin
      n_errors++;
      $display("FAIL resp_err: got %b want %b", resp_err, hang);
    end
    n_checks++;
    if (resp_product !== ep) begin
      n_errors++;
      $display("FAIL resp_product: got %h want %h", resp_product, ep);
    end
    n_checks++;
    if ({mul_in_A, mul_in_B, busy} !== {ea, eb, 1'b1}) begin
      n_errors++;
      $display("FAIL hold_operands: got %h %h busy=%b want %h %h 1",
               mul_in_A, mul_in_B, busy, ea, eb);
    end
    ref_ptr = (win + 1) % NR;
    if (!keep) req = '0;
    @(negedge clk);
    n_checks++;
    if ({grant, resp_valid, busy} !== {{NR{1'b0}}, {NR{1'b0}}, 1'b0}) begin
      n_errors++;
      $display("FAIL idle_after_resp: got grant=%b rv=%b busy=%b want 0 0 0",
               grant, resp_valid, busy);
    end
    n_checks++;
    if ({resp_err, resp_product} !== {hang, ep}) begin
      n_errors++;
      $display("FAIL result_hold: got %b %h want %b %h",
               resp_err, resp_product, hang, ep);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #12;
    n_checks++;
    if ({grant, resp_valid, resp_err, resp_product, busy, mul_ld, mul_ld_PP,
         mul_in_A, mul_in_B} !== '0) begin
      n_errors++;
      $display("FAIL reset_outputs: got grant=%b rv=%b busy=%b prod=%h", grant,
               resp_valid, busy, resp_product);
    end
    @(negedge clk);
    reset = 1'b1;
    ref_ptr = 0;
    @(negedge clk);
  endtask

  task automatic test_single();
    run_op(4'b0001, {48'h0, 16'd3}, {48'h0, 16'hFFFB}, 16, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_round_robin();
    logic [NR*WI-1:0] a, b;
    for (int i = 0; i < NR; i++) begin
      a[i*WI +: WI] = WI'(i + 1);
      b[i*WI +: WI] = WI'(2);
    end
    for (int n = 0; n < 5; n++)
      run_op(4'b1111, a, b, 16, 1'b0, (n < 4), 1'b0);
  endtask

  task automatic test_timeout();
    run_op(4'b0010, {$urandom, $urandom}, {$urandom, $urandom}, 0, 1'b1,
           1'b0, 1'b0);
    run_op(4'b0010, {$urandom, $urandom}, {$urandom, $urandom}, 5, 1'b0,
           1'b0, 1'b0);
  endtask

  task automatic test_collision();
    run_op(4'b1000, {$urandom, $urandom}, {$urandom, $urandom}, TO - 1, 1'b0,
           1'b0, 1'b0);
    extra_ldp = 1'b1;
    @(negedge clk);
    extra_ldp = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if ({grant, resp_valid, busy, mul_ld} !== '0) begin
        n_errors++;
        $display("FAIL idle_ldp: got grant=%b rv=%b busy=%b ld=%b want 0",
                 grant, resp_valid, busy, mul_ld);
      end
    end
  endtask

  task automatic test_latching();
    run_op(4'b0100, {4{16'h8000}}, {4{16'h8000}}, 10, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_random();
    for (int n = 0; n < 20; n++)
      run_op(NR'($urandom_range(1, 15)), {$urandom, $urandom},
             {$urandom, $urandom}, $urandom_range(0, 30),
             ($urandom_range(0, 7) == 0), 1'b0, ($urandom_range(0, 3) == 0));
  endtask

  task automatic test_reset_mid();
    int cyc;
    m_hang = 1'b1;
    req = 4'b0001;
    req_a = {$urandom, $urandom};
    req_b = {$urandom, $urandom};
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (grant == '0 && cyc < 6);
    req = '0;
    repeat (6) @(negedge clk);
    n_checks++;
    if (busy !== 1'b1) begin
      n_errors++;
      $display("FAIL busy_in_wait: got %b want 1", busy);
    end
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if ({grant, resp_valid, resp_err, resp_product, busy, mul_ld, mul_ld_PP,
         mul_in_A, mul_in_B} !== '0) begin
      n_errors++;
      $display("FAIL async_reset: got grant=%b rv=%b busy=%b prod=%h a=%h",
               grant, resp_valid, busy, resp_product, mul_in_A);
    end
    @(negedge clk);
    reset = 1'b1;
    m_hang = 1'b0;
    ref_ptr = 0;
    @(negedge clk);
    run_op(4'b0100, {$urandom, $urandom}, {$urandom, $urandom}, 3, 1'b0,
           1'b0, 1'b0);
    run_op(4'b1111, {$urandom, $urandom}, {$urandom, $urandom}, 7, 1'b0,
           1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_collision();
    test_latching();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
